mcd_id_timing: RTL and testbench
================================

MCD_ID_TIMING -- requirements
Module: mcd_id_timing

Interface
REQ-001 Parameter DLY2, default 25, meaning stage-2 delay in clock cycles (2500 ns at 100 ns/cycle); legal range 1..255.
REQ-002 Parameter DLY3, default 15, meaning stage-3 delay in clock cycles (1500 ns at 100 ns/cycle); legal range 1..255.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 syncv  in  1  memory sync pulse.
REQ-006 rdmv  in  1  read-memory request, active-high.
REQ-007 rdmvn  in  1  complement of the read request, active-high meaning store.
REQ-008 brova  in  1  buffer-register-A select.
REQ-009 brovb  in  1  buffer-register-B select.
REQ-010 bra  in  14  buffer register A data, bits [14:1].
REQ-011 brb  in  14  buffer register B data, bits [14:1].
REQ-012 strp1, strp2, strp3  out  1 each  store pulse, stage 1/2/3.
REQ-013 rdp1, rdp2, rdp3  out  1 each  read pulse, stage 1/2/3.
REQ-014 inh  out  14  latched inhibit pattern, bits [14:1].
REQ-015 edm  out  1  core drive enable.

Function
REQ-016 Coincidence stage (mcd1): strp1 SHALL be registered from (rdmvn AND syncv), one cycle latency.
REQ-017 Coincidence stage (mcd1): rdp1 SHALL be registered from (syncv AND rdmv), one cycle latency.
REQ-018 Delay stage (mcd2): strp2 SHALL equal strp1 delayed by exactly DLY2 cycles, and strp3 SHALL equal strp2 delayed by exactly DLY3 cycles.
REQ-019 Delay stage (mcd2): rdp2 and rdp3 SHALL follow rdp1 with the same DLY2 and DLY3 delays.
REQ-020 Each delay stage SHALL preserve pulse width and handle back-to-back or overlapping pulses without loss; implement as a shift line, not a retriggerable counter.
REQ-021 Inhibit driver (id), per bit i: on the clock edge where strp2 is first seen high (previous-cycle strp2 = 0, current = 1), inh[i] SHALL load (bra[i] AND brova) OR (brb[i] AND brovb).
REQ-022 inh SHALL hold its value at all other times, including while strp2 stays high.
REQ-023 If brova and brovb are both high, inh SHALL be the OR of both terms; if both are low, inh SHALL load 0.
REQ-024 edm SHALL be combinational: rdp3 OR strp3.
REQ-025 When syncv is high with rdmv and rdmvn both high, read and store chains SHALL both fire independently; no arbitration.

Reset
REQ-026 While reset is high at a clock edge, all pipeline/delay registers, the strp2 edge-detect flop and inh SHALL clear to 0.
REQ-027 Consequently strp1..3, rdp1..3, inh and edm SHALL all read 0 the cycle after reset.
REQ-028 A reset asserted mid-pulse SHALL discard every in-flight pulse; no stage may emit it after reset releases.
REQ-029 After reset releases, the first valid strp1/rdp1 SHALL appear one cycle after a qualifying input.

Verification
REQ-030 Store pulse: syncv=1, rdmvn=1, rdmv=0 for 1 cycle at cycle 0 -> strp1 high at cycle 1, strp2 at cycle 26, strp3 at cycle 41, edm high at cycle 41 only; rdp* stay 0.
REQ-031 Read pulse: syncv=1, rdmv=1 for 3 cycles -> rdp1 high for 3 cycles, rdp3 high for 3 cycles starting cycle 41, edm high for those 3 cycles.
REQ-032 Inhibit latch: bra=14'h2AAA, brova=1, brovb=0, then store pulse -> inh=14'h2AAA from the cycle after strp2 rises; bra changed to 0 afterwards leaves inh unchanged.
REQ-033 Inhibit OR case: bra=14'h00FF, brb=14'h3F00, brova=brovb=1, store pulse -> inh=14'h3FFF; both selects 0 -> next store pulse yields inh=0.
REQ-034 Reset mid-flight: store pulse at cycle 0, reset high at cycle 10 for 1 cycle -> strp2, strp3, edm never assert; inh stays 0.
REQ-035 Back-to-back: store pulses at cycles 0 and 2 -> strp3 pulses at cycles 41 and 43, each 1 cycle wide.

Source files
------------

// File: rtl/mcd_id_timing.sv
// Memory core drive timing chain: store/read pulse coincidence, two fixed delay
// stages built as shift lines, inhibit pattern latch and core drive enable.
module mcd_id_timing #(
   parameter int DLY2 = 25,
   parameter int DLY3 = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        syncv,
   input  logic        rdmv,
   input  logic        rdmvn,
   input  logic        brova,
   input  logic        brovb,
   input  logic [14:1] bra,
   input  logic [14:1] brb,
   output logic        strp1,
   output logic        strp2,
   output logic        strp3,
   output logic        rdp1,
   output logic        rdp2,
   output logic        rdp3,
   output logic [14:1] inh,
   output logic        edm
);

   logic [DLY2-1:0] st_line2;
   logic [DLY2-1:0] rd_line2;
   logic [DLY3-1:0] st_line3;
   logic [DLY3-1:0] rd_line3;
   logic            strp2_q;

   // Tap 0 of each line is one cycle behind its input, so the last tap is
   // exactly DLYn cycles behind.
   assign strp2 = st_line2[DLY2-1];
   assign rdp2  = rd_line2[DLY2-1];
   assign strp3 = st_line3[DLY3-1];
   assign rdp3  = rd_line3[DLY3-1];
   assign edm   = rdp3 | strp3;

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the delay lines are plain flops, not RAM, and are cleared so
         // that a reset discards every pulse still in flight.
         strp1    <= 1'b0;
         rdp1     <= 1'b0;
         st_line2 <= '0;
         rd_line2 <= '0;
         st_line3 <= '0;
         rd_line3 <= '0;
         strp2_q  <= 1'b0;
         inh      <= '0;
      end else begin
         // NOTE: non-blocking assignments make every tap read its neighbour's
         // old value, so the loop below shifts rather than flushes the line.
         strp1 <= rdmvn & syncv;
         rdp1  <= syncv & rdmv;

         st_line2[0] <= strp1;
         rd_line2[0] <= rdp1;
         for (int i = 1; i < DLY2; i++) begin
            st_line2[i] <= st_line2[i-1];
            rd_line2[i] <= rd_line2[i-1];
         end

         st_line3[0] <= strp2;
         rd_line3[0] <= rdp2;
         for (int i = 1; i < DLY3; i++) begin
            st_line3[i] <= st_line3[i-1];
            rd_line3[i] <= rd_line3[i-1];
         end

         // Latch the inhibit pattern only on the rising edge of strp2.
         strp2_q <= strp2;
         if (strp2 && !strp2_q)
            inh <= (bra & {14{brova}}) | (brb & {14{brovb}});
      end
   end

endmodule

// File: tb/tb_mcd_id_timing.sv
// Bench for mcd_id_timing: directed scenarios then random traffic, every cycle
// compared against a pulse-survival model built from the recorded input history.
module tb_mcd_id_timing;

   localparam int D2   = 25;
   localparam int D3   = 15;
   localparam int L1   = 1;
   localparam int L2   = 1 + D2;
   localparam int L3   = 1 + D2 + D3;
   localparam int MAXC = 6000;

   logic        clk = 1'b0;
   logic        reset, syncv, rdmv, rdmvn, brova, brovb;
   logic [14:1] bra, brb;
   logic        strp1, strp2, strp3, rdp1, rdp2, rdp3, edm;
   logic [14:1] inh;

   mcd_id_timing #(.DLY2(D2), .DLY3(D3)) dut (
      .clk   (clk),
      .reset (reset),
      .syncv (syncv),
      .rdmv  (rdmv),
      .rdmvn (rdmvn),
      .brova (brova),
      .brovb (brovb),
      .bra   (bra),
      .brb   (brb),
      .strp1 (strp1),
      .strp2 (strp2),
      .strp3 (strp3),
      .rdp1  (rdp1),
      .rdp2  (rdp2),
      .rdp3  (rdp3),
      .inh   (inh),
      .edm   (edm)
   );

   always #5 clk = ~clk;

   // Input history, indexed by the cycle in which the value was presented.
   bit        h_rst   [MAXC];
   bit        h_store [MAXC];
   bit        h_read  [MAXC];
   bit [13:0] h_pat   [MAXC];

   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          edm_hits = 0;
   logic [13:0] exp_inh = '0;

   // A pulse requested in cycle t-lat is seen at cycle t unless a reset was
   // presented anywhere in its flight window [t-lat, t-1].
   function automatic bit pulse_at(input bit is_read, input int t, input int lat);
      int s;
      s = t - lat;
      if (s < 0) return 1'b0;
      for (int u = s; u < t; u++)
         if (h_rst[u]) return 1'b0;
      return is_read ? h_read[s] : h_store[s];
   endfunction

   task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
      end
   endtask

   task automatic tick();
      bit st2_now, st2_prev;
      h_rst[cyc]   = reset;
      h_store[cyc] = syncv & rdmvn;
      h_read[cyc]  = syncv & rdmv;
      h_pat[cyc]   = (bra & {14{brova}}) | (brb & {14{brovb}});
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      // The pattern presented in cycle t-1 is captured when strp2 is high in
      // t-1 but was low in t-2.
      st2_now  = pulse_at(1'b0, cyc - 1, L2);
      st2_prev = (cyc >= 2) ? pulse_at(1'b0, cyc - 2, L2) : 1'b0;
      if (h_rst[cyc-1])
         exp_inh = '0;
      else if (st2_now && !st2_prev)
         exp_inh = h_pat[cyc-1];
      if (edm === 1'b1) edm_hits++;
      check("strp1", {13'd0, strp1}, {13'd0, pulse_at(1'b0, cyc, L1)});
      check("strp2", {13'd0, strp2}, {13'd0, pulse_at(1'b0, cyc, L2)});
      check("strp3", {13'd0, strp3}, {13'd0, pulse_at(1'b0, cyc, L3)});
      check("rdp1",  {13'd0, rdp1},  {13'd0, pulse_at(1'b1, cyc, L1)});
      check("rdp2",  {13'd0, rdp2},  {13'd0, pulse_at(1'b1, cyc, L2)});
      check("rdp3",  {13'd0, rdp3},  {13'd0, pulse_at(1'b1, cyc, L3)});
      check("edm",   {13'd0, edm},
            {13'd0, pulse_at(1'b0, cyc, L3) | pulse_at(1'b1, cyc, L3)});
      check("inh",   inh, exp_inh);
   endtask

   task automatic idle(input int n);
      syncv = 1'b0;
      rdmv  = 1'b0;
      rdmvn = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic store_pulse();
      syncv = 1'b1;
      rdmv  = 1'b0;
      rdmvn = 1'b1;
      tick();
      syncv = 1'b0;
      rdmvn = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      syncv = 1'b0;
      rdmv  = 1'b0;
      rdmvn = 1'b0;
      brova = 1'b0;
      brovb = 1'b0;
      bra   = '0;
      brb   = '0;

      // Reset state.
      tick();
      tick();
      tick();
      check("reset_inh", inh, 14'h0000);
      check("reset_edm", {13'd0, edm}, 14'h0000);
      reset = 1'b0;
      idle(2);

      // Single store pulse: strp2 at +26, strp3/edm at +41.
      store_pulse();
      idle(50);

      // Three-cycle read pulse.
      syncv = 1'b1;
      rdmv  = 1'b1;
      rdmvn = 1'b0;
      repeat (3) tick();
      idle(50);

      // Inhibit latch from register A; later changes to bra must not leak in.
      bra   = 14'h2AAA;
      brova = 1'b1;
      brovb = 1'b0;
      store_pulse();
      idle(30);
      bra = 14'h0000;
      idle(25);
      check("inh_latch_a", inh, 14'h2AAA);

      // Both selects high ORs the two terms; both low loads zero.
      bra   = 14'h00FF;
      brb   = 14'h3F00;
      brova = 1'b1;
      brovb = 1'b1;
      store_pulse();
      idle(45);
      check("inh_or", inh, 14'h3FFF);
      brova = 1'b0;
      brovb = 1'b0;
      store_pulse();
      idle(45);
      check("inh_none", inh, 14'h0000);

      // Reset mid-flight: nothing may emerge afterwards.
      bra      = 14'h1234;
      brova    = 1'b1;
      edm_hits = 0;
      store_pulse();
      idle(9);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle(50);
      check("rst_flight_edm", edm_hits[13:0], 14'd0);
      check("rst_flight_inh", inh, 14'h0000);

      // Back-to-back store pulses two cycles apart.
      edm_hits = 0;
      store_pulse();
      idle(1);
      store_pulse();
      idle(50);
      check("b2b_edm_cycles", edm_hits[13:0], 14'd2);

      // Random traffic, including simultaneous read/store and random resets.
      for (int i = 0; i < 2500; i++) begin
         reset = ($urandom_range(0, 149) == 0);
         syncv = ($urandom_range(0, 4) == 0);
         rdmv  = $urandom_range(0, 1);
         rdmvn = ($urandom_range(0, 2) != 0);
         brova = $urandom_range(0, 1);
         brovb = $urandom_range(0, 1);
         bra   = 14'($urandom);
         brb   = 14'($urandom);
         tick();
      end
      reset = 1'b0;
      idle(60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
